// File: rtl/sram_cache_ctrl_pkg.sv
// Shared constants and types for the direct-mapped write-through cache controller
// and its wordline decoder.
package cache_pkg;

  localparam int IDX_W  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int LINES  = 2 ** IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    FILL,
    UPDATE,
    MEM_WR
  } ctrl_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } addr_t;

endpackage

// File: rtl/sram_cache_ctrl_wl_decoder.sv
// Combinational index to one-hot SRAM wordline decoder.
module wl_decoder
  import cache_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [LINES-1:0] wl
);

  always_comb begin
    wl      = '0;
    wl[idx] = 1'b1;
  end

endmodule

// File: rtl/sram_cache_ctrl.sv
// Direct-mapped write-through cache controller driving a 16-line tag/data SRAM.
// Optional hit/miss counters are enabled with `define SRAM_CACHE_STATS_EN.
module sram_cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              sram_we,
  output logic [LINES-1:0]  sram_wl,
  output logic [TAG_W-1:0]  sram_tag_in,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [TAG_W-1:0]  sram_tag_out,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef SRAM_CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  ctrl_state_t       state_q, state_d;
  addr_t             addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              hit_q, hit_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              done_q, done_d;
  logic              cpu_hit_q, cpu_hit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              lookup_hit;

  assign lookup_hit = valid_q[addr_q.idx] && (sram_tag_out == addr_q.tag);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    fill_d    = fill_q;
    hit_d     = hit_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    cpu_hit_d = cpu_hit_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = addr_t'(cpu_addr);
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          hit_d   = lookup_hit;
          state_d = UPDATE;
        end else if (lookup_hit) begin
          rdata_d   = sram_data_out;
          cpu_hit_d = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        valid_d[addr_q.idx] = 1'b1;
        rdata_d             = fill_q;
        cpu_hit_d           = 1'b0;
        done_d              = 1'b1;
        state_d             = IDLE;
      end
      UPDATE: begin
        // Write-allocate: the line is (re)claimed before the memory write.
        valid_d[addr_q.idx] = 1'b1;
        state_d             = MEM_WR;
      end
      MEM_WR: begin
        if (mem_ack) begin
          cpu_hit_d = hit_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      fill_q    <= '0;
      hit_q     <= 1'b0;
      valid_q   <= '0;
      done_q    <= 1'b0;
      cpu_hit_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      fill_q    <= fill_d;
      hit_q     <= hit_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      cpu_hit_q <= cpu_hit_d;
      rdata_q   <= rdata_d;
    end
  end

  wl_decoder u_wl_decoder (
    .idx (addr_q.idx),
    .wl  (sram_wl)
  );

  // Memory-side outputs come straight from state so reset drops mem_req at once.
  assign cpu_ready    = (state_q == IDLE);
  assign cpu_done     = done_q;
  assign cpu_hit      = cpu_hit_q;
  assign cpu_rdata    = rdata_q;
  assign sram_we      = (state_q == FILL) || (state_q == UPDATE);
  assign sram_tag_in  = addr_q.tag;
  assign sram_data_in = (state_q == FILL) ? fill_q : wdata_q;
  assign mem_req      = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_we       = (state_q == MEM_WR);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

`ifdef SRAM_CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (done_d) begin
      if (cpu_hit_d) hit_cnt_d  = sat_inc(hit_cnt_q);
      else           miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
